// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hold/flush scheduler.
// Imported by the controller and its bus-wait timer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_BUS_WAIT,
    ST_EX_WAIT,
    ST_FLUSH
  } state_e;

  localparam logic HOLD_ON  = 1'b1;
  localparam logic FLUSH_ON = 1'b1;

  localparam int WAIT_CNT_W = 8;

  function automatic logic src_hit(
    input logic       used,
    input logic [4:0] rs,
    input logic [4:0] rd
  );
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and hold/flush controls between pipeline and scheduler.
// master = pipeline side, slave = pipe_ctrl.
interface pipe_ctrl_if;
  logic [4:0]  id_rs1_addr_i;
  logic [4:0]  id_rs2_addr_i;
  logic        id_rs1_used_i;
  logic        id_rs2_used_i;
  logic        ex_is_load_i;
  logic        ex_regw_enable_i;
  logic [4:0]  ex_rd_addr_i;
  logic        ex_jump_flag_i;
  logic [31:0] ex_jump_addr_i;
  logic        ex_busy_i;
  logic        bus_req_i;
  logic        bus_gnt_i;
  logic        hold_pc_o;
  logic        hold_if_id_o;
  logic        hold_id_ex_o;
  logic        hold_ex_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        bus_timeout_o;
  logic [31:0] stall_cnt_o;

  modport master (
    output id_rs1_addr_i, id_rs2_addr_i,
    output id_rs1_used_i, id_rs2_used_i,
    output ex_is_load_i, ex_regw_enable_i,
    output ex_rd_addr_i, ex_jump_flag_i,
    output ex_jump_addr_i, ex_busy_i,
    output bus_req_i, bus_gnt_i,
    input  hold_pc_o, hold_if_id_o,
    input  hold_id_ex_o, hold_ex_o,
    input  flush_if_id_o, flush_id_ex_o,
    input  jump_flag_o, jump_addr_o,
    input  bus_timeout_o, stall_cnt_o
  );

  modport slave (
    input  id_rs1_addr_i, id_rs2_addr_i,
    input  id_rs1_used_i, id_rs2_used_i,
    input  ex_is_load_i, ex_regw_enable_i,
    input  ex_rd_addr_i, ex_jump_flag_i,
    input  ex_jump_addr_i, ex_busy_i,
    input  bus_req_i, bus_gnt_i,
    output hold_pc_o, hold_if_id_o,
    output hold_id_ex_o, hold_ex_o,
    output flush_if_id_o, flush_id_ex_o,
    output jump_flag_o, jump_addr_o,
    output bus_timeout_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl_bus_wait_timer.sv
// Counts consecutive ungranted bus cycles and pulses on the last one.
// The count restarts after the pulse or any cycle without a wait.
module pipe_ctrl_bus_wait_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_wait,
  output logic o_timeout
);

  localparam logic [WAIT_CNT_W-1:0] LAST =
    WAIT_CNT_W'(BUS_TIMEOUT - 1);

  logic [WAIT_CNT_W-1:0] r_cnt;

  assign o_timeout = i_wait && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || !i_wait || o_timeout)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush scheduler: bus wait > EX busy > jump > load-use.
// Drives per-stage holds, flushes, PC redirect and stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int BUS_TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  state_e      r_state, w_state_nxt;
  logic [1:0]  r_fcnt, w_fcnt_nxt;
  logic [31:0] r_stall;

  logic w_bus_wait, w_load_use, w_timeout;
  logic w_fpend;
  logic w_ev_bus, w_ev_busy, w_ev_jump;
  logic w_ev_flush, w_ev_lu;

  logic        w_hold_pc, w_hold_if_id;
  logic        w_hold_id_ex, w_hold_ex;
  logic        w_flush_if_id, w_flush_id_ex;
  logic        w_jf;
  logic [31:0] w_ja;

  assign w_bus_wait = bus.bus_req_i & ~bus.bus_gnt_i;

  assign w_load_use = bus.ex_is_load_i
    & bus.ex_regw_enable_i
    & (bus.ex_rd_addr_i != 5'd0)
    & (src_hit(bus.id_rs1_used_i,
               bus.id_rs1_addr_i,
               bus.ex_rd_addr_i)
     | src_hit(bus.id_rs2_used_i,
               bus.id_rs2_addr_i,
               bus.ex_rd_addr_i));

  assign w_fpend = (r_fcnt != 2'd0);

  // Mutually exclusive events in priority order
  assign w_ev_bus   = w_bus_wait;
  assign w_ev_busy  = ~w_bus_wait & bus.ex_busy_i;
  assign w_ev_jump  = ~w_bus_wait & ~bus.ex_busy_i
                    & bus.ex_jump_flag_i;
  assign w_ev_flush = ~w_bus_wait & ~bus.ex_busy_i
                    & ~bus.ex_jump_flag_i & w_fpend;
  assign w_ev_lu    = ~w_bus_wait & ~bus.ex_busy_i
                    & ~bus.ex_jump_flag_i & ~w_fpend
                    & w_load_use;

  pipe_ctrl_bus_wait_timer #(
    .BUS_TIMEOUT(BUS_TIMEOUT)
  ) u_bus_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .i_wait   (w_bus_wait),
    .o_timeout(w_timeout)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_fcnt_nxt    = r_fcnt;
    w_hold_pc     = 1'b0;
    w_hold_if_id  = 1'b0;
    w_hold_id_ex  = 1'b0;
    w_hold_ex     = 1'b0;
    w_flush_if_id = 1'b0;
    w_flush_id_ex = 1'b0;
    w_jf          = 1'b0;
    w_ja          = 32'd0;
    if (rst) begin
      w_flush_if_id = FLUSH_ON;
      w_flush_id_ex = FLUSH_ON;
      w_state_nxt   = ST_RUN;
      w_fcnt_nxt    = 2'd0;
    end else begin
      unique case (1'b1)
        w_ev_bus: begin
          if (w_timeout) begin
            w_state_nxt = w_fpend ? ST_FLUSH : ST_RUN;
          end else begin
            w_hold_pc    = HOLD_ON;
            w_hold_if_id = HOLD_ON;
            w_hold_id_ex = HOLD_ON;
            w_hold_ex    = HOLD_ON;
            w_state_nxt  = ST_BUS_WAIT;
          end
        end
        w_ev_busy: begin
          w_hold_pc    = HOLD_ON;
          w_hold_if_id = HOLD_ON;
          w_hold_id_ex = HOLD_ON;
          w_state_nxt  = (r_state == ST_FLUSH) ?
                         ST_FLUSH : ST_EX_WAIT;
        end
        w_ev_jump: begin
          w_jf          = 1'b1;
          w_ja          = bus.ex_jump_addr_i;
          w_flush_if_id = FLUSH_ON;
          w_flush_id_ex = FLUSH_ON;
          w_fcnt_nxt    = 2'(FLUSH_CYCLES - 1);
          w_state_nxt   = (FLUSH_CYCLES > 1) ?
                          ST_FLUSH : ST_RUN;
        end
        w_ev_flush: begin
          w_flush_if_id = FLUSH_ON;
          w_fcnt_nxt    = r_fcnt - 2'd1;
          w_state_nxt   = (r_fcnt == 2'd1) ?
                          ST_RUN : ST_FLUSH;
        end
        w_ev_lu: begin
          w_hold_pc     = HOLD_ON;
          w_hold_if_id  = HOLD_ON;
          w_flush_id_ex = FLUSH_ON;
          w_state_nxt   = ST_RUN;
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_fcnt  <= 2'd0;
      r_stall <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
      if (w_hold_pc)
        r_stall <= r_stall + 32'd1;
    end
  end

  assign bus.hold_pc_o     = w_hold_pc;
  assign bus.hold_if_id_o  = w_hold_if_id;
  assign bus.hold_id_ex_o  = w_hold_id_ex;
  assign bus.hold_ex_o     = w_hold_ex;
  assign bus.flush_if_id_o = w_flush_if_id;
  assign bus.flush_id_ex_o = w_flush_id_ex;
  assign bus.jump_flag_o   = w_jf;
  assign bus.jump_addr_o   = w_ja;
  assign bus.bus_timeout_o = w_ev_bus & w_timeout;
  assign bus.stall_cnt_o   = r_stall;

endmodule
